fifo_uart_tx: RTL
=================

# fifo_uart_tx

Drain stage for the synchronous FIFO (`fifo_syn`): pops one word at a time and serialises it on a UART line, 8N1 style (start bit, WIDTH data bits LSB first, one stop bit). Sits directly downstream of the FIFO read port; it is the FIFO's only reader. It generates its own bit timing from the system clock, so a FIFO fill burst becomes a back-to-back frame stream.

## Interface
- `WIDTH`, 8: data bits per frame; must equal the FIFO `WIDTH`.
- `CLK_FREQ`, 50_000_000: clk frequency in Hz.
- `BAUD`, 115200: line rate. `BAUD_DIV = CLK_FREQ / BAUD`, integer truncation, giving 434 at the defaults. `BAUD_DIV` ≥ 2 is required; the bit counter is sized by clogb2(`BAUD_DIV`) + 1.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_q`  in  WIDTH  FIFO `q`. It is registered and valid the cycle after a pop.
- `fifo_rd`  out  1  pop request to FIFO `rd`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of each frame.

## Operation
- States:
  - IDLE: if `fifo_empty`=0, go to FETCH.
  - FETCH: `fifo_rd`=1 for exactly this cycle, then LOAD.
  - LOAD: capture `fifo_q` into the shift register, then START.
  - START: `tx`=0 for BAUD_DIV cycles, then DATA.
  - DATA: each bit is held for BAUD_DIV cycles. Shift right after each bit, LSB first. The bit index counts 0..WIDTH-1, then STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles, then IDLE.
- `fifo_rd` is decoded from state FETCH only. It is never asserted in any other state.
  - FETCH is entered only after `fifo_empty`=0 was sampled. No other reader exists, so the pop is always accepted.
  - Exactly one pop occurs per frame. A word is never read twice.
- `tx` is 1 in IDLE, FETCH, LOAD and STOP, 0 in START, and equals shift[0] in DATA.
- Baud counter:
  - Counts 0..BAUD_DIV-1.
  - Clears on every bit boundary and on entry to START.
  - Does not run in IDLE, FETCH or LOAD.
- `frame_done` = 1 in the cycle after the last STOP cycle, coincident with the first IDLE cycle.
- `fifo_empty` changing mid-frame has no effect. It is sampled only in IDLE.
- Reset values while `rst` is high, applied asynchronously:
  - state=IDLE, `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0.
  - Counters and shift register are 0.
- Reset mid-frame: the line returns high immediately. The in-flight word is discarded; it has already been popped and is not re-fetched. There is no `frame_done` pulse for it.
- After deassertion of `rst`, the first possible `fifo_rd` is in the second cycle, with IDLE sampled first.

## Timing
- Let E0 be the edge that samples IDLE with `fifo_empty`=0.
  - `fifo_rd` is high for the cycle after E0.
  - The FIFO updates `q` at E1.
  - The shift register loads at E2, and `tx` falls after E2.
- Frame length from the `tx` fall to the end of stop is (WIDTH+2)·BAUD_DIV cycles.
- `frame_done` rises at edge E2 + (WIDTH+2)·BAUD_DIV.
- Back-to-back frames: the IDLE, FETCH and LOAD overhead is 3 cycles. Successive `tx` falling edges are therefore (WIDTH+2)·BAUD_DIV + 3 cycles apart.
- Throughput is one word per frame period. The FIFO's `full` back-pressure is handled entirely upstream.

## Test plan
All scenarios use WIDTH=8, CLK_FREQ=1000, BAUD=100, so BAUD_DIV=10 and a frame is 100 cycles.
- **Reset/idle:** hold `rst`=1, then release with `fifo_empty`=1 for 200 cycles → `tx`=1, `fifo_rd`=0, `busy`=0, `frame_done`=0 throughout.
- **Single word 0xA5:**
  - Expect one `fifo_rd` pulse, then `tx` low 2 cycles later.
  - The line reads start 0, then bits 1,0,1,0,0,1,0,1, each exactly 10 cycles, then stop 1 for 10 cycles.
  - `frame_done` pulses once, 100 cycles after the `tx` fall.
  - `busy` is high from FETCH to the end of stop.
- **Back-to-back, real `fifo_syn` (DEPTH 8) loaded with 0x00, 0xFF, 0x55:**
  - Three `fifo_rd` pulses and three frames, with `tx` falls 103 cycles apart.
  - Data bits decode to 0x00, 0xFF, 0x55 in that order.
  - FIFO empty after the third pop; no fourth `fifo_rd`.
- **Empty mid-frame, then refill:**
  - Write 0x3C while a frame is in progress.
  - No `fifo_rd` until the IDLE after stop; then exactly one pop and a 0x3C frame.
- **Reset mid-frame:**
  - Assert `rst` during data bit 3 of 0xA5 → `tx`=1 asynchronously (before the next clk edge) and `busy`=0, with no `frame_done`.
  - After release, the next queued word is sent intact and 0xA5 is not resent.
- **FIFO full burst:**
  - Fill the FIFO with 8 words 0x01..0x08 → 8 frames in order.
  - Exactly 8 `fifo_rd` pulses; `usedw` steps down by 1 per frame; `empty`=1 at the end.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops one word from the upstream FIFO and shifts it out 8N1 (start, WIDTH bits LSB first, stop).
// Frame is (WIDTH+2)*BAUD_DIV cycles plus 3 cycles IDLE/FETCH/LOAD overhead; one pop per frame.
module fifo_uart_tx #(
   parameter int WIDTH    = 8,
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_q,
   output logic             fifo_rd,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   function automatic int clogb2(input int value);
      int n;
      n = 0;
      for (int v = value - 1; v > 0; v = v >> 1) n++;
      return n;
   endfunction

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CNTW     = clogb2(BAUD_DIV) + 1;
   localparam int IDXW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BAUD_DIV - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   state_t           state, state_nx;
   logic [CNTW-1:0]  cnt, cnt_nx;
   logic [IDXW-1:0]  idx, idx_nx;
   logic [WIDTH-1:0] shift, shift_nx;
   logic             tx_nx;
   logic             done_nx;
   logic             bit_end;

   assign bit_end = (cnt == CNT_LAST);
   assign fifo_rd = (state == FETCH);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         shift      <= shift_nx;
         tx         <= tx_nx;
         frame_done <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      shift_nx = shift;
      done_nx  = 1'b0;
      tx_nx    = 1'b1;

      case (state)
         IDLE: begin
            if (!fifo_empty) state_nx = FETCH;
         end
         FETCH: begin
            state_nx = LOAD;
         end
         LOAD: begin
            // fifo_q is valid here, one cycle after the pop in FETCH
            shift_nx = fifo_q;
            cnt_nx   = '0;
            idx_nx   = '0;
            state_nx = START;
         end
         START: begin
            if (bit_end) begin
               cnt_nx   = '0;
               state_nx = DATA;
            end else begin
               cnt_nx = cnt + CNTW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nx   = '0;
               shift_nx = shift >> 1;
               if (idx == IDX_LAST) begin
                  idx_nx   = '0;
                  state_nx = STOP;
               end else begin
                  idx_nx = idx + IDXW'(1);
               end
            end else begin
               cnt_nx = cnt + CNTW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_nx   = '0;
               done_nx  = 1'b1;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNTW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      // tx is registered, so it is derived from the upcoming state and shift contents
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

endmodule
